// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with bit-serial logical shifts and registered result/flags
module seq_alu #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Out,
  output logic         Zero,
  output logic         Carry,
  output logic         Neg
);
  localparam logic [2:0] ADD = 3'b000, LSL = 3'b001, XOR = 3'b010, AND = 3'b011;
  localparam logic [2:0] CMP = 3'b100, SET = 3'b101, LSR = 3'b110, SUB = 3'b111;
  localparam logic [W-1:0]  W_MAX = W[W-1:0];
  localparam logic [CW-1:0] W_CNT = W[CW-1:0];
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [W-1:0] w_q, w_d, out_q, out_d, res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, carry_q, carry_d, neg_q, neg_d, upd;
  logic [W:0] sum, dif;
  // next state, working shift register, and result/flag commit on entry to FIN
  always_comb begin
    sum = {1'b0, InA} + {1'b0, InB};
    dif = {1'b0, InA} - {1'b0, InB};
    state_d = state_q;
    op_d = op_q;
    w_d = w_q;
    cnt_d = cnt_q;
    out_d = out_q;
    carry_d = carry_q;
    res = out_q;
    upd = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        op_d = Op;
        w_d = InA;
        cnt_d = (InB >= W_MAX) ? W_CNT : InB[CW-1:0];
        if ((Op == LSL || Op == LSR) && InB != '0) begin
          state_d = SHIFT;
        end else begin
          state_d = FIN;
          upd = 1'b1;
          case (Op)
            ADD:      begin res = sum[W-1:0]; carry_d = sum[W]; end
            SUB, CMP: begin res = dif[W-1:0]; carry_d = ~dif[W]; end
            XOR:      begin res = InA ^ InB; carry_d = 1'b0; end
            AND:      begin res = InA & InB; carry_d = 1'b0; end
            SET:      res = InB;
            default:  begin res = InA; carry_d = 1'b0; end
          endcase
          out_d = (Op == CMP) ? out_q : res;
        end
      end
      SHIFT: begin
        w_d = (op_q == LSR) ? w_q >> 1 : w_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d = FIN;
          upd = 1'b1;
          res = w_d;
          out_d = w_d;
          carry_d = (op_q == LSR) ? w_q[0] : w_q[W-1];
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = upd ? (res == '0) : zero_q;
    neg_d = upd ? res[W-1] : neg_q;
  end
  // state and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q <= '0;
      w_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      w_q <= w_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
      neg_q <= neg_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign Done = state_q == FIN;
  assign Out = out_q;
  assign Zero = zero_q;
  assign Carry = carry_q;
  assign Neg = neg_q;
endmodule
